divisor_arbiter: RTL and testbench

Round-robin scheduler sharing one pipelined signed divider (`Divisor_Algoritmico_Segmentado`, fixed latency, one new operation accepted per cycle) among `NREQ` requesters. Grants at most one division per cycle and forwards operands to the divider. Carries requester ID and divide-by-zero flag alongside each in-flight operation in a tag shift register, and routes each result to its originator on a shared response bus. Sits between the requester ports and the divider in the arithmetic subsystem.

---
 rtl/divisor_arbiter.sv | 139 +++++++++++++
 tb/tb_divisor_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_arbiter.sv
// Round-robin front end that shares one pipelined signed divider among NREQ requesters.
// A tag shift register tracks owner and divide-by-zero per in-flight op and steers each result back.
module divisor_arbiter_lane #(
  parameter int TAMANYO = 32,
  parameter int IDW     = 2,
  parameter int ID      = 0
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic [TAMANYO-1:0] den,
  input  logic               head_v,
  input  logic [IDW-1:0]     head_id,
  output logic               dz,
  output logic               rsp_vld
);
  assign dz = (den == '0);

  always_ff @(posedge CLK or posedge RSTa)
    if (RSTa) rsp_vld <= 1'b0;
    else      rsp_vld <= head_v && (head_id == IDW'(ID));
endmodule

module divisor_arbiter #(
  parameter int TAMANYO = 32,
  parameter int NREQ    = 4,
  parameter int LAT     = 32
) (
  input  logic                           CLK,
  input  logic                           RSTa,
  input  logic [NREQ-1:0]                Req,
  input  logic [NREQ-1:0][TAMANYO-1:0]   NumIn,
  input  logic [NREQ-1:0][TAMANYO-1:0]   DenIn,
  input  logic                           Hold,
  output logic [NREQ-1:0]                Ack,
  output logic                           DivStart,
  output logic [TAMANYO-1:0]             DivNum,
  output logic [TAMANYO-1:0]             DivDen,
  input  logic                           DivDone,
  input  logic [TAMANYO-1:0]             DivCoc,
  input  logic [TAMANYO-1:0]             DivRes,
  output logic [NREQ-1:0]                RspValid,
  output logic [TAMANYO-1:0]             RspCoc,
  output logic [TAMANYO-1:0]             RspRes,
  output logic                           RspDz,
  output logic                           Busy,
  output logic                           Err
);
  localparam int IDW = $clog2(NREQ);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           dz;
  } tag_t;

  logic [IDW-1:0]  last, gnt_id;
  logic            gnt;
  logic [NREQ-1:0] dz_vec;
  logic [LAT:0]    vld_pipe;
  tag_t [LAT:0]    tag_pipe;
  tag_t            head, new_tag;

  // Index 'off' positions after 'base', wrapping modulo NREQ (NREQ need not be a power of two).
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  always_comb begin
    Ack    = '0;
    gnt    = 1'b0;
    gnt_id = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt && !Hold && !RSTa && Req[rr_idx(last, k)]) begin
        gnt    = 1'b1;
        gnt_id = rr_idx(last, k);
      end
    end
    if (gnt) Ack[gnt_id] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RSTa)
    if (RSTa) begin
      last     <= IDW'(NREQ-1);
      DivStart <= 1'b0;
      DivNum   <= '0;
      DivDen   <= '0;
    end else begin
      DivStart <= gnt;
      if (gnt) begin
        last   <= gnt_id;
        DivNum <= NumIn[gnt_id];
        DivDen <= DenIn[gnt_id];
      end
    end

  assign new_tag = '{id: gnt_id, dz: dz_vec[gnt_id]};
  assign head    = tag_pipe[LAT];

  // Entry LAT lines up with the cycle the divider raises Done for that op.
  always_ff @(posedge CLK or posedge RSTa)
    if (RSTa) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:0], gnt};
      tag_pipe <= {tag_pipe[LAT-1:0], new_tag};
    end

  always_ff @(posedge CLK or posedge RSTa)
    if (RSTa) begin
      RspCoc <= '0;
      RspRes <= '0;
      RspDz  <= 1'b0;
      Err    <= 1'b0;
    end else begin
      if (vld_pipe[LAT] != DivDone) Err <= 1'b1;
      if (vld_pipe[LAT]) begin
        RspCoc <= head.dz ? '0 : DivCoc;
        RspRes <= head.dz ? '0 : DivRes;
        RspDz  <= head.dz;
      end
    end

  assign Busy = (|vld_pipe) | DivStart;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    divisor_arbiter_lane #(.TAMANYO(TAMANYO), .IDW(IDW), .ID(i)) u_lane (
      .CLK     (CLK),
      .RSTa    (RSTa),
      .den     (DenIn[i]),
      .head_v  (vld_pipe[LAT]),
      .head_id (head.id),
      .dz      (dz_vec[i]),
      .rsp_vld (RspValid[i])
    );
  end
endmodule

// File: tb/tb_divisor_arbiter.sv
// Randomized scoreboard bench for divisor_arbiter with a behavioural divider stand-in.
module tb_divisor_arbiter;
  localparam int TAMANYO = 32;
  localparam int NREQ    = 4;
  localparam int LAT     = 32;

  logic                         CLK = 1'b0;
  logic                         RSTa;
  logic [NREQ-1:0]              Req;
  logic [NREQ-1:0][TAMANYO-1:0] NumIn, DenIn;
  logic                         Hold;
  logic [NREQ-1:0]              Ack;
  logic                         DivStart;
  logic [TAMANYO-1:0]           DivNum, DivDen;
  logic                         DivDone;
  logic [TAMANYO-1:0]           DivCoc, DivRes;
  logic [NREQ-1:0]              RspValid;
  logic [TAMANYO-1:0]           RspCoc, RspRes;
  logic                         RspDz, Busy, Err;

  divisor_arbiter #(.TAMANYO(TAMANYO), .NREQ(NREQ), .LAT(LAT)) dut (
    .CLK(CLK), .RSTa(RSTa), .Req(Req), .NumIn(NumIn), .DenIn(DenIn), .Hold(Hold),
    .Ack(Ack), .DivStart(DivStart), .DivNum(DivNum), .DivDen(DivDen),
    .DivDone(DivDone), .DivCoc(DivCoc), .DivRes(DivRes),
    .RspValid(RspValid), .RspCoc(RspCoc), .RspRes(RspRes), .RspDz(RspDz),
    .Busy(Busy), .Err(Err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Divider stand-in: latency LAT from sampled Start; 'late' delays Done one extra cycle.
  logic               dv [LAT];
  logic [TAMANYO-1:0] dn [LAT];
  logic [TAMANYO-1:0] dd [LAT];
  logic               late = 1'b0, done_d;
  always @(posedge CLK or posedge RSTa)
    if (RSTa) begin
      for (int j = 0; j < LAT; j++) dv[j] <= 1'b0;
      done_d <= 1'b0;
    end else begin
      dv[0] <= DivStart; dn[0] <= DivNum; dd[0] <= DivDen;
      for (int j = 1; j < LAT; j++) begin
        dv[j] <= dv[j-1]; dn[j] <= dn[j-1]; dd[j] <= dd[j-1];
      end
      done_d <= dv[LAT-1];
    end
  assign DivDone = late ? done_d : dv[LAT-1];
  always_comb begin
    DivCoc = 32'hDEADBEEF;
    DivRes = 32'hDEADBEEF;
    if (dd[LAT-1] != 0) begin
      DivCoc = $signed(dn[LAT-1]) / $signed(dd[LAT-1]);
      DivRes = $signed(dn[LAT-1]) % $signed(dd[LAT-1]);
    end
  end

  // Reference arithmetic from magnitudes: truncate toward zero, remainder follows dividend.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sd, ma, md, mq, rr;
    if (b == 0) begin q = 0; r = 0; dz = 1'b1; return; end
    sa = longint'($signed(a)); sd = longint'($signed(b));
    ma = (sa < 0) ? -sa : sa;  md = (sd < 0) ? -sd : sd;
    mq = ma / md;
    if ((sa < 0) != (sd < 0)) mq = -mq;
    rr = sa - mq * sd;
    q = mq[31:0]; r = rr[31:0]; dz = 1'b0;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] q, r;
    logic        dz;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic        rq [NREQ];
  logic [31:0] mn [NREQ], md [NREQ];
  int          last_m;
  logic        err_ok = 1'b0;

  always @(negedge CLK) begin
    if (!RSTa) begin
      if (!err_ok) check("err_clear", 64'(Err), 64'd0);
      if (RspValid != 0) begin
        if (sb.size() == 0) check("rsp_unexpected", 64'(RspValid), 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_valid", 64'(RspValid), 64'(1 << e.id));
          check("rsp_coc",   64'(RspCoc),   64'(e.q));
          check("rsp_res",   64'(RspRes),   64'(e.r));
          check("rsp_dz",    64'(RspDz),    64'(e.dz));
          check("rsp_cycle", 64'(cyc),      64'(e.due));
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        check("rsp_missing", 64'(RspValid), 64'(1 << sb[0].id));
        void'(sb.pop_front());
      end
    end
  end

  task automatic step(input logic hold);
    int g;
    exp_t e;
    @(negedge CLK);
    Hold = hold;
    for (int i = 0; i < NREQ; i++) begin
      Req[i] = rq[i]; NumIn[i] = mn[i]; DenIn[i] = md[i];
    end
    #1;
    g = -1;
    if (!hold)
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && rq[(last_m + k) % NREQ]) g = (last_m + k) % NREQ;
    check("ack", 64'(Ack), (g >= 0) ? 64'(1 << g) : 64'd0);
    if (g >= 0) begin
      e.id = g; e.due = cyc + LAT + 2;
      ref_div(mn[g], md[g], e.q, e.r, e.dz);
      sb.push_back(e);
      last_m = g;
      rq[g]  = 1'b0;
    end
  endtask

  task automatic new_op(input int i);
    logic [31:0] a, b;
    a = $urandom();
    b = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($signed($urandom_range(0, 400)) - 200);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
    rq[i] = 1'b1; mn[i] = a; md[i] = b;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    rq[i] = 1'b1; mn[i] = 32'(a); md[i] = 32'(b);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) rq[i] = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK); #2; n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #2;
    RSTa = 1'b1;
    sb.delete();
    last_m = NREQ - 1;
    clear_reqs();
    Req = '1; Hold = 1'b0;
    late = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_ack",      64'(Ack),      64'd0);
    check("rst_divstart", 64'(DivStart), 64'd0);
    check("rst_divnum",   64'(DivNum),   64'd0);
    check("rst_divden",   64'(DivDen),   64'd0);
    check("rst_rspvalid", 64'(RspValid), 64'd0);
    check("rst_rspcoc",   64'(RspCoc),   64'd0);
    check("rst_rspres",   64'(RspRes),   64'd0);
    check("rst_rspdz",    64'(RspDz),    64'd0);
    check("rst_busy",     64'(Busy),     64'd0);
    check("rst_err",      64'(Err),      64'd0);
    @(posedge CLK); #2;
    RSTa = 1'b0;
    Req  = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    RSTa = 1'b1; Req = '0; NumIn = '0; DenIn = '0; Hold = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rq[i] = 1'b0; mn[i] = 0; md[i] = 0; end
    last_m = NREQ - 1;
    do_reset();

    // Single op 100/7 from requester 0.
    set_op(0, 100, 7);
    step(1'b0);
    step(1'b0);
    check("start_after_ack", 64'(DivStart), 64'd1);
    check("divnum_issued",   64'(DivNum),   64'd100);
    check("divden_issued",   64'(DivDen),   64'd7);
    check("busy_inflight",   64'(Busy),     64'd1);
    wait_drain();

    // All four requesting continuously; requester 2 starts with -100/7.
    for (int i = 0; i < NREQ; i++) new_op(i);
    set_op(2, -100, 7);
    repeat (24) begin
      step(1'b0);
      for (int i = 0; i < NREQ; i++) if (!rq[i]) new_op(i);
    end
    clear_reqs();
    step(1'b0);
    wait_drain();

    // Divide by zero then a normal op on the same requester.
    set_op(3, 5, 0);
    step(1'b0);
    set_op(3, 9, 3);
    step(1'b0);
    clear_reqs();
    step(1'b0);
    wait_drain();

    // Hold with all requesting while three ops are in flight.
    set_op(0, 1000, -7); set_op(1, -77, -5); set_op(2, 12345, 100);
    repeat (3) step(1'b0);
    for (int i = 0; i < NREQ; i++) new_op(i);
    repeat (10) step(1'b1);
    check("busy_during_hold", 64'(Busy), 64'd1);
    clear_reqs();
    step(1'b1);
    wait_drain();
    @(negedge CLK); #1;
    check("busy_after_drain", 64'(Busy), 64'd0);

    // Randomized traffic with withdrawals and random Hold.
    repeat (300) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rq[i] && $urandom_range(0, 2) == 0) new_op(i);
        else if (rq[i] && $urandom_range(0, 9) == 0) rq[i] = 1'b0;
      end
      step($urandom_range(0, 7) == 0);
    end
    clear_reqs();
    step(1'b0);
    wait_drain();

    // Reset five cycles after issuing four ops: they must vanish.
    for (int i = 0; i < NREQ; i++) new_op(i);
    repeat (4) step(1'b0);
    clear_reqs();
    repeat (5) step(1'b0);
    do_reset();
    check("busy_after_rst", 64'(Busy), 64'd0);
    repeat (40) step(1'b0);
    for (int i = 0; i < NREQ; i++) new_op(i);
    step(1'b0);
    check("first_after_rst", 64'(Ack), 64'd1);
    clear_reqs();
    step(1'b0);
    wait_drain();

    // Done arrives one cycle late: Err sticks until reset.
    err_ok = 1'b1;
    late   = 1'b1;
    set_op(1, 50, 6);
    step(1'b0);
    clear_reqs();
    step(1'b0);
    wait_drain();
    repeat (2) @(negedge CLK);
    #1;
    check("err_set", 64'(Err), 64'd1);
    repeat (5) @(negedge CLK);
    #1;
    check("err_sticky", 64'(Err), 64'd1);
    do_reset();
    err_ok = 1'b0;
    repeat (3) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
